// File: rtl/rv_decode_exec_pkg.sv
// Shared RV64I decode constants, operation enum and small helpers for rv_decode_exec.
package rv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [5:0] {
    OP_ILLEGAL = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
    OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW
  } op_e;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic is_branch(input op_e op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) ||
           (op == OP_BGE) || (op == OP_BLTU) || (op == OP_BGEU);
  endfunction

endpackage

// File: rtl/rv_decode_exec_if.sv
// Instruction-in / stage-2-out bundle of rv_decode_exec; the core uses the slave modport.
interface rv_decode_exec_if;
  import rv_pkg::*;

  logic            instr_valid;
  logic [ILEN-1:0] instr;
  logic [XLEN-1:0] pc;
  logic            display_regs;
  logic            s2_valid;
  op_e             s2_op;
  logic [4:0]      s2_rd;
  logic [XLEN-1:0] s2_rs1_val;
  logic [XLEN-1:0] s2_rs2_val;
  logic [XLEN-1:0] s2_imm;
  logic [XLEN-1:0] s2_pc;
  logic [XLEN-1:0] alu_result;
  logic            wr_en;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            illegal;

  modport master (
    output instr_valid, instr, pc, display_regs,
    input  s2_valid, s2_op, s2_rd, s2_rs1_val, s2_rs2_val, s2_imm, s2_pc,
    input  alu_result, wr_en, br_taken, br_target, illegal
  );

  modport slave (
    input  instr_valid, instr, pc, display_regs,
    output s2_valid, s2_op, s2_rd, s2_rs1_val, s2_rs2_val, s2_imm, s2_pc,
    output alu_result, wr_en, br_taken, br_target, illegal
  );

endinterface

// File: rtl/rv_decode_exec_alu.sv
// Combinational RV64I execute unit: result, branch/jump decision and redirect target.
module rv_alu
  import rv_pkg::*;
(
  input  op_e             i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_result,
  output logic            o_taken,
  output logic [XLEN-1:0] o_target
);

  // Execute: one arm per decoded operation
  always_comb begin
    o_result = '0;
    o_taken  = 1'b0;
    o_target = i_pc + i_imm;
    case (i_op)
      OP_LUI:   o_result = i_imm;
      OP_AUIPC: o_result = i_pc + i_imm;
      OP_JAL:   begin o_result = i_pc + 64'd4; o_taken = 1'b1; end
      OP_JALR:  begin o_result = i_pc + 64'd4; o_taken = 1'b1; o_target = (i_a + i_imm) & ~64'd1; end
      OP_BEQ:   o_taken = (i_a == i_b);
      OP_BNE:   o_taken = (i_a != i_b);
      OP_BLT:   o_taken = ($signed(i_a) < $signed(i_b));
      OP_BGE:   o_taken = ($signed(i_a) >= $signed(i_b));
      OP_BLTU:  o_taken = (i_a < i_b);
      OP_BGEU:  o_taken = (i_a >= i_b);
      OP_ADDI:  o_result = i_a + i_imm;
      OP_SLTI:  o_result = {63'd0, $signed(i_a) < $signed(i_imm)};
      OP_SLTIU: o_result = {63'd0, i_a < i_imm};
      OP_XORI:  o_result = i_a ^ i_imm;
      OP_ORI:   o_result = i_a | i_imm;
      OP_ANDI:  o_result = i_a & i_imm;
      OP_SLLI:  o_result = i_a << i_imm[5:0];
      OP_SRLI:  o_result = i_a >> i_imm[5:0];
      OP_SRAI:  o_result = $signed(i_a) >>> i_imm[5:0];
      OP_ADD:   o_result = i_a + i_b;
      OP_SUB:   o_result = i_a - i_b;
      OP_SLL:   o_result = i_a << i_b[5:0];
      OP_SLT:   o_result = {63'd0, $signed(i_a) < $signed(i_b)};
      OP_SLTU:  o_result = {63'd0, i_a < i_b};
      OP_XOR:   o_result = i_a ^ i_b;
      OP_SRL:   o_result = i_a >> i_b[5:0];
      OP_SRA:   o_result = $signed(i_a) >>> i_b[5:0];
      OP_OR:    o_result = i_a | i_b;
      OP_AND:   o_result = i_a & i_b;
      OP_ADDIW: o_result = sext32(i_a[31:0] + i_imm[31:0]);
      OP_SLLIW: o_result = sext32(i_a[31:0] << i_imm[4:0]);
      OP_SRLIW: o_result = sext32(i_a[31:0] >> i_imm[4:0]);
      OP_SRAIW: o_result = sext32($signed(i_a[31:0]) >>> i_imm[4:0]);
      OP_ADDW:  o_result = sext32(i_a[31:0] + i_b[31:0]);
      OP_SUBW:  o_result = sext32(i_a[31:0] - i_b[31:0]);
      OP_SLLW:  o_result = sext32(i_a[31:0] << i_b[4:0]);
      OP_SRLW:  o_result = sext32(i_a[31:0] >> i_b[4:0]);
      OP_SRAW:  o_result = sext32($signed(i_a[31:0]) >>> i_b[4:0]);
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/rv_decode_exec.sv
// RV64I decode + execute stage pair with 32x64 register file and stage-2 forwarding.
// Optional register dump on display_regs rising edge when RV_DISPLAY_REGS_EN is defined.
module rv_decode_exec
  import rv_pkg::*;
(
  input logic            clk,
  input logic            reset,
  rv_decode_exec_if.slave bus
);

  logic [XLEN-1:0] r_rf [32];
  logic            r_s2_valid;
  op_e             r_s2_op;
  logic [4:0]      r_s2_rd;
  logic [XLEN-1:0] r_s2_rs1_val, r_s2_rs2_val, r_s2_imm, r_s2_pc;

  logic [6:0]      w_opc, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1, w_rs2;
  logic [XLEN-1:0] w_imm_i, w_imm_b, w_imm_u, w_imm_j, w_imm;
  op_e             w_op;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_alu_res, w_br_target;
  logic            w_alu_taken, w_wr_en;

  assign w_opc   = bus.instr[6:0];
  assign w_f3    = bus.instr[14:12];
  assign w_f7    = bus.instr[31:25];
  assign w_rs1   = bus.instr[19:15];
  assign w_rs2   = bus.instr[24:20];
  assign w_imm_i = {{52{bus.instr[31]}}, bus.instr[31:20]};
  assign w_imm_b = {{51{bus.instr[31]}}, bus.instr[31], bus.instr[7], bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign w_imm_u = sext32({bus.instr[31:12], 12'd0});
  assign w_imm_j = {{43{bus.instr[31]}}, bus.instr[31], bus.instr[19:12], bus.instr[20], bus.instr[30:21], 1'b0};

  // Decode opcode/funct fields into an operation and its immediate
  always_comb begin
    w_op  = OP_ILLEGAL;
    w_imm = w_imm_i;
    case (w_opc)
      OPC_LUI:    begin w_op = OP_LUI;   w_imm = w_imm_u; end
      OPC_AUIPC:  begin w_op = OP_AUIPC; w_imm = w_imm_u; end
      OPC_JAL:    begin w_op = OP_JAL;   w_imm = w_imm_j; end
      OPC_JALR:   w_op = (w_f3 == F3_ADD) ? OP_JALR : OP_ILLEGAL;
      OPC_BRANCH: begin
        w_imm = w_imm_b;
        case (w_f3)
          F3_BEQ:  w_op = OP_BEQ;
          F3_BNE:  w_op = OP_BNE;
          F3_BLT:  w_op = OP_BLT;
          F3_BGE:  w_op = OP_BGE;
          F3_BLTU: w_op = OP_BLTU;
          F3_BGEU: w_op = OP_BGEU;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      OPC_OP_IMM: begin
        case (w_f3)
          F3_ADD:  w_op = OP_ADDI;
          F3_SLT:  w_op = OP_SLTI;
          F3_SLTU: w_op = OP_SLTIU;
          F3_XOR:  w_op = OP_XORI;
          F3_OR:   w_op = OP_ORI;
          F3_AND:  w_op = OP_ANDI;
          F3_SLL:  w_op = (bus.instr[31:26] == 6'b000000) ? OP_SLLI : OP_ILLEGAL;
          F3_SR:   begin
            if (bus.instr[31:26] == 6'b000000)      w_op = OP_SRLI;
            else if (bus.instr[31:26] == 6'b010000) w_op = OP_SRAI;
            else                                    w_op = OP_ILLEGAL;
          end
          default: w_op = OP_ILLEGAL;
        endcase
      end
      OPC_OP: begin
        if (w_f7 == F7_BASE) begin
          case (w_f3)
            F3_ADD:  w_op = OP_ADD;
            F3_SLL:  w_op = OP_SLL;
            F3_SLT:  w_op = OP_SLT;
            F3_SLTU: w_op = OP_SLTU;
            F3_XOR:  w_op = OP_XOR;
            F3_SR:   w_op = OP_SRL;
            F3_OR:   w_op = OP_OR;
            F3_AND:  w_op = OP_AND;
            default: w_op = OP_ILLEGAL;
          endcase
        end else if (w_f7 == F7_ALT && w_f3 == F3_ADD) begin
          w_op = OP_SUB;
        end else if (w_f7 == F7_ALT && w_f3 == F3_SR) begin
          w_op = OP_SRA;
        end else begin
          w_op = OP_ILLEGAL;
        end
      end
      OPC_OP_IMM_32: begin
        case (w_f3)
          F3_ADD:  w_op = OP_ADDIW;
          F3_SLL:  w_op = (w_f7 == F7_BASE) ? OP_SLLIW : OP_ILLEGAL;
          F3_SR:   begin
            if (w_f7 == F7_BASE)     w_op = OP_SRLIW;
            else if (w_f7 == F7_ALT) w_op = OP_SRAIW;
            else                     w_op = OP_ILLEGAL;
          end
          default: w_op = OP_ILLEGAL;
        endcase
      end
      OPC_OP_32: begin
        if (w_f7 == F7_BASE && w_f3 == F3_ADD)     w_op = OP_ADDW;
        else if (w_f7 == F7_BASE && w_f3 == F3_SLL) w_op = OP_SLLW;
        else if (w_f7 == F7_BASE && w_f3 == F3_SR)  w_op = OP_SRLW;
        else if (w_f7 == F7_ALT && w_f3 == F3_ADD)  w_op = OP_SUBW;
        else if (w_f7 == F7_ALT && w_f3 == F3_SR)   w_op = OP_SRAW;
        else                                        w_op = OP_ILLEGAL;
      end
      default: w_op = OP_ILLEGAL;
    endcase
  end

  assign w_wr_en = r_s2_valid && (r_s2_rd != 5'd0) && (r_s2_op != OP_ILLEGAL) && !is_branch(r_s2_op);

  // Operand read: x0 is hard zero, stage-2 result bypasses the register file
  always_comb begin
    if (w_rs1 == 5'd0)                       w_rs1_val = '0;
    else if (w_wr_en && (r_s2_rd == w_rs1)) w_rs1_val = w_alu_res;
    else                                     w_rs1_val = r_rf[w_rs1];
    if (w_rs2 == 5'd0)                       w_rs2_val = '0;
    else if (w_wr_en && (r_s2_rd == w_rs2)) w_rs2_val = w_alu_res;
    else                                     w_rs2_val = r_rf[w_rs2];
  end

  // Stage-2 latch; a cycle without instr_valid becomes a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_valid   <= 1'b0;
      r_s2_op      <= OP_ILLEGAL;
      r_s2_rd      <= 5'd0;
      r_s2_rs1_val <= '0;
      r_s2_rs2_val <= '0;
      r_s2_imm     <= '0;
      r_s2_pc      <= '0;
    end else if (bus.instr_valid) begin
      r_s2_valid   <= 1'b1;
      r_s2_op      <= w_op;
      r_s2_rd      <= bus.instr[11:7];
      r_s2_rs1_val <= w_rs1_val;
      r_s2_rs2_val <= w_rs2_val;
      r_s2_imm     <= w_imm;
      r_s2_pc      <= bus.pc;
    end else begin
      r_s2_valid   <= 1'b0;
    end
  end

  // Register file writeback; reset wipes every entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (w_wr_en) begin
      r_rf[r_s2_rd] <= w_alu_res;
    end
  end

  rv_alu u_alu (
    .i_op     (r_s2_op),
    .i_a      (r_s2_rs1_val),
    .i_b      (r_s2_rs2_val),
    .i_imm    (r_s2_imm),
    .i_pc     (r_s2_pc),
    .o_result (w_alu_res),
    .o_taken  (w_alu_taken),
    .o_target (w_br_target)
  );

  assign bus.s2_valid   = r_s2_valid;
  assign bus.s2_op      = r_s2_op;
  assign bus.s2_rd      = r_s2_rd;
  assign bus.s2_rs1_val = r_s2_rs1_val;
  assign bus.s2_rs2_val = r_s2_rs2_val;
  assign bus.s2_imm     = r_s2_imm;
  assign bus.s2_pc      = r_s2_pc;
  assign bus.alu_result = w_alu_res;
  assign bus.wr_en      = w_wr_en;
  assign bus.br_taken   = r_s2_valid && w_alu_taken;
  assign bus.br_target  = w_br_target;
  assign bus.illegal    = r_s2_valid && (r_s2_op == OP_ILLEGAL);

`ifdef RV_DISPLAY_REGS_EN
  logic r_disp_q;

  // Dump the register file once per display_regs rising edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_disp_q <= 1'b0;
    end else begin
      r_disp_q <= bus.display_regs;
      if (bus.display_regs && !r_disp_q) begin
        for (int i = 0; i < 32; i++) $display("x%0d = %016h", i, r_rf[i]);
      end
    end
  end
`else
  logic w_unused_display;
  assign w_unused_display = bus.display_regs;
`endif

endmodule

// File: tb/tb_rv_decode_exec.sv
// Randomized bench for rv_decode_exec against an architectural RV64I model kept in the bench.
module tb_rv_decode_exec;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv_decode_exec_if bus ();
  rv_decode_exec dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit          valid, ill, wr, br, chk_res, chk_tgt, chk_ops;
    int          lit_kind;   // 0 none, 1 alu_result, 2 br_target
    logic [4:0]  rd;
    logic [63:0] res, tgt, pc, rs1v, rs2v, lit;
  } exp_t;

  exp_t        q[$];
  exp_t        ce;
  logic [63:0] regs [32];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural execution of one instruction; updates the model register array.
  function automatic exp_t model(input logic [31:0] in, input logic [63:0] pc);
    exp_t e;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [63:0] a, b, s_i, s_b, s_j, s_u, r;
    logic [31:0] lo;
    logic signed [11:0] ti;
    logic signed [12:0] tbr;
    logic signed [20:0] tj;
    logic signed [31:0] tu;
    bit ill, wb;
    e = '{default: '0};
    opc = in[6:0]; f3 = in[14:12]; f7 = in[31:25];
    a = regs[in[19:15]]; b = regs[in[24:20]];
    ti = in[31:20]; tbr = {in[31], in[7], in[30:25], in[11:8], 1'b0};
    tj = {in[31], in[19:12], in[20], in[30:21], 1'b0}; tu = {in[31:12], 12'h000};
    s_i = ti; s_b = tbr; s_j = tj; s_u = tu;
    r = 64'd0; lo = 32'd0; ill = 1'b0; wb = 1'b1;
    case (opc)
      7'h37: r = s_u;
      7'h17: r = pc + s_u;
      7'h6f: begin r = pc + 64'd4; e.br = 1'b1; e.tgt = pc + s_j; e.chk_tgt = 1'b1; end
      7'h67: if (f3 != 3'd0) ill = 1'b1;
             else begin r = pc + 64'd4; e.br = 1'b1; e.tgt = (a + s_i) & ~64'd1; e.chk_tgt = 1'b1; end
      7'h63: begin
        wb = 1'b0; e.tgt = pc + s_b; e.chk_tgt = 1'b1; e.chk_ops = 1'b1;
        case (f3)
          3'd0: e.br = (a == b);
          3'd1: e.br = (a != b);
          3'd4: e.br = ($signed(a) < $signed(b));
          3'd5: e.br = ($signed(a) >= $signed(b));
          3'd6: e.br = (a < b);
          3'd7: e.br = (a >= b);
          default: ill = 1'b1;
        endcase
      end
      7'h13: case (f3)
        3'd0: r = a + s_i;
        3'd2: r = ($signed(a) < $signed(s_i)) ? 64'd1 : 64'd0;
        3'd3: r = (a < s_i) ? 64'd1 : 64'd0;
        3'd4: r = a ^ s_i;
        3'd6: r = a | s_i;
        3'd7: r = a & s_i;
        3'd1: if (in[31:26] == 6'd0) r = a << in[25:20]; else ill = 1'b1;
        default: if (in[31:26] == 6'd0) r = a >> in[25:20];
                 else if (in[31:26] == 6'h10) r = $signed(a) >>> in[25:20];
                 else ill = 1'b1;
      endcase
      7'h33: begin
        e.chk_ops = 1'b1;
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: r = a + b;
            3'd1: r = a << b[5:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd3: r = (a < b) ? 64'd1 : 64'd0;
            3'd4: r = a ^ b;
            3'd5: r = a >> b[5:0];
            3'd6: r = a | b;
            default: r = a & b;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) r = a - b;
        else if (f7 == 7'h20 && f3 == 3'd5) r = $signed(a) >>> b[5:0];
        else ill = 1'b1;
      end
      7'h1b, 7'h3b: begin
        logic [31:0] bw;
        logic [4:0]  sh;
        bw = (opc == 7'h1b) ? s_i[31:0] : b[31:0];
        sh = (opc == 7'h1b) ? in[24:20] : b[4:0];
        if (opc == 7'h3b) e.chk_ops = 1'b1;
        if (f3 == 3'd0 && (opc == 7'h1b || f7 == 7'h00)) lo = a[31:0] + bw;
        else if (f3 == 3'd0 && f7 == 7'h20) lo = a[31:0] - bw;
        else if (f3 == 3'd1 && f7 == 7'h00) lo = a[31:0] << sh;
        else if (f3 == 3'd5 && f7 == 7'h00) lo = a[31:0] >> sh;
        else if (f3 == 3'd5 && f7 == 7'h20) lo = $signed(a[31:0]) >>> sh;
        else ill = 1'b1;
        r = $signed(lo);
      end
      default: ill = 1'b1;
    endcase
    e.valid = 1'b1; e.pc = pc; e.rd = in[11:7]; e.ill = ill;
    e.br = e.br && !ill; e.chk_tgt = e.chk_tgt && !ill;
    e.chk_res = !ill && wb; e.res = r; e.rs1v = a; e.rs2v = b;
    e.wr = !ill && wb && (in[11:7] != 5'd0);
    if (e.wr) regs[in[11:7]] = r;
    return e;
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] r, w;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    r = $urandom(); w = $urandom();
    rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 11))
      0: w = {r[31:12], rd, 7'h37};
      1: w = {r[31:12], rd, 7'h17};
      2: w = {r[31:12], rd, 7'h6f};
      3: w = {r[31:20], rs1, 3'b000, rd, 7'h67};
      4: w = {r[31:25], rs2, rs1, f3, r[11:7], 7'h63};
      5, 6: begin
        w = {r[31:20], rs1, f3, rd, 7'h13};
        if (f3 == 3'd1) w[31:26] = 6'h00;
        if (f3 == 3'd5) w[31:26] = r[0] ? 6'h10 : 6'h00;
      end
      7, 8: w = {(r[0] ? 7'h20 : 7'h00), rs2, rs1, f3, rd, 7'h33};
      9: begin
        w = {r[31:20], rs1, f3, rd, 7'h1b};
        if (f3 == 3'd1) w[31:25] = 7'h00;
        if (f3 == 3'd5) w[31:25] = r[0] ? 7'h20 : 7'h00;
      end
      10: w = {(r[0] ? 7'h20 : 7'h00), rs2, rs1, f3, rd, 7'h3b};
      default: w = r;
    endcase
    return w;
  endfunction

  task automatic step(input bit v, input logic [31:0] in, input logic [63:0] pc,
                      input int lk = 0, input logic [63:0] lit = 64'd0);
    exp_t e;
    bus.instr_valid = v; bus.instr = in; bus.pc = pc;
    if (v) e = model(in, pc);
    else   e = '{default: '0};
    e.lit_kind = lk; e.lit = lit;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  // Single compare point: stage-2 outputs against the expectation for that cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      ce = q.pop_front();
      check("s2_valid", 64'(bus.s2_valid), 64'(ce.valid));
      check("wr_en", 64'(bus.wr_en), 64'(ce.wr));
      check("br_taken", 64'(bus.br_taken), 64'(ce.br));
      check("illegal", 64'(bus.illegal), 64'(ce.ill));
      if (ce.valid) begin
        check("s2_rd", 64'(bus.s2_rd), 64'(ce.rd));
        check("s2_pc", bus.s2_pc, ce.pc);
        if (ce.chk_res) check("alu_result", bus.alu_result, ce.res);
        if (ce.chk_tgt) check("br_target", bus.br_target, ce.tgt);
        if (ce.chk_ops) check("s2_rs1_val", bus.s2_rs1_val, ce.rs1v);
        if (ce.chk_ops) check("s2_rs2_val", bus.s2_rs2_val, ce.rs2v);
      end
      if (ce.lit_kind == 1) check("lit_result", bus.alu_result, ce.lit);
      if (ce.lit_kind == 2) check("lit_target", bus.br_target, ce.lit);
    end
  end

  initial begin
    logic [63:0] pc;
    bus.instr_valid = 1'b0; bus.instr = 32'd0; bus.pc = 64'd0; bus.display_regs = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s2_valid", 64'(bus.s2_valid), 64'd0);
    check("rst_wr_en", 64'(bus.wr_en), 64'd0);
    check("rst_illegal", 64'(bus.illegal), 64'd0);
    check("rst_s2_pc", bus.s2_pc, 64'd0);
    reset = 1'b1;

    step(1'b1, 32'h00500093, 64'h0, 1, 64'd5);
    step(1'b1, 32'h00108133, 64'h4, 1, 64'd10);
    step(1'b1, 32'h401001B3, 64'h8, 1, 64'hFFFFFFFFFFFFFFFB);
    step(1'b1, 32'h800000B7, 64'hC, 1, 64'hFFFFFFFF80000000);
    step(1'b1, 32'h00000463, 64'h1000, 2, 64'h1008);
    step(1'b1, 32'h00000000, 64'h1004);

    // Asynchronous reset in the middle of the illegal instruction's cycle
    @(negedge clk);
    #1;
    bus.instr_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("arst_s2_valid", 64'(bus.s2_valid), 64'd0);
    check("arst_illegal", 64'(bus.illegal), 64'd0);
    check("arst_wr_en", 64'(bus.wr_en), 64'd0);
    check("arst_br_taken", 64'(bus.br_taken), 64'd0);
    check("arst_s2_op", 64'(bus.s2_op), 64'd0);
    check("arst_s2_rd", 64'(bus.s2_rd), 64'd0);
    check("arst_s2_imm", bus.s2_imm, 64'd0);
    check("arst_s2_pc", bus.s2_pc, 64'd0);
    check("arst_alu_result", bus.alu_result, 64'd0);
    for (int i = 0; i < 32; i++) regs[i] = 64'd0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b1, 32'h000082B3, 64'h2000, 1, 64'd0);

    pc = 64'h4000;
    for (int n = 0; n < 3000; n++) begin
      bus.display_regs = (n % 100) < 3;
      if ($urandom_range(0, 7) == 0) step(1'b0, $urandom(), pc);
      else step(1'b1, gen(), pc);
      if ($urandom_range(0, 15) == 0) pc = {$urandom(), $urandom()} & ~64'd3;
      else pc = pc + 64'd4;
    end
    bus.display_regs = 1'b0;
    step(1'b0, 32'd0, pc);
    @(negedge clk);
    #1;
    check("drain", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
